// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous 16-bit SRAM; every access runs IDLE->ACC1->ACC2->DONE.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module sram_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [19:0] ADDR0,
  input  logic [19:0] ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        Done0,
  output logic        Done1,
  output logic [15:0] RDATA,
  output logic        Busy,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Drive_EN,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC1 = 2'b01;
  localparam logic [1:0] ACC2 = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [19:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        we_reg;
  logic        id_reg;
  logic [15:0] rdata_reg;

  logic        any_req;
  logic        grant;
  logic        grant_id;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_we;
  logic        in_access;

  assign any_req = Req0 | Req1;
  assign grant   = (state_reg == IDLE) && any_req;

`ifdef SRAM_ARB_RR_EN
  // Remembers the last granted port; the other port wins the next tie.
  logic last_reg;

  always_comb begin
    grant_id = Req1;
    if (Req0 && Req1) begin
      grant_id = ~last_reg;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_reg <= 1'b0;
    end else if (grant) begin
      last_reg <= grant_id;
    end
  end
`else
  always_comb begin
    grant_id = ~Req0;
  end
`endif

  always_comb begin
    sel_addr  = ADDR0;
    sel_wdata = WDATA0;
    sel_we    = WE0;
    if (grant_id) begin
      sel_addr  = ADDR1;
      sel_wdata = WDATA1;
      sel_we    = WE1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACC1;
      ACC1:    state_next = ACC2;
      ACC2:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The SRAM side only ever sees these copies, so port inputs may churn mid-access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_reg  <= 20'h00000;
      wdata_reg <= 16'h0000;
      we_reg    <= 1'b0;
      id_reg    <= 1'b0;
    end else if (grant) begin
      addr_reg  <= sel_addr;
      wdata_reg <= sel_wdata;
      we_reg    <= sel_we;
      id_reg    <= grant_id;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_reg <= 16'h0000;
    end else if ((state_reg == ACC2) && !we_reg) begin
      rdata_reg <= Data_from_SRAM;
    end
  end

  assign in_access = (state_reg == ACC1) || (state_reg == ACC2);

  // OE and WE are decoded from the same latched op bit, so they cannot overlap.
  assign Mem_OE       = ~(in_access && !we_reg);
  assign Mem_WE       = ~(in_access && we_reg);
  assign Drive_EN     = in_access && we_reg;
  assign Mem_CE       = 1'b0;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;

  assign ADDR         = addr_reg;
  assign Data_to_SRAM = wdata_reg;
  assign RDATA        = rdata_reg;
  assign Busy         = (state_reg != IDLE);
  assign Done0        = (state_reg == DONE) && !id_reg;
  assign Done1        = (state_reg == DONE) && id_reg;

endmodule
